mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for HI/LO instructions, sitting beside the EX stage.
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU from EX and stalls the pipeline while it works.
- Owns a shared iterative divider and a registered multiply-accumulate path.
- Presents one HI/LO write for one cycle when an operation completes.
- Replaces ad-hoc stall/counter feedback through the ID/EX register.

Parameters:
- DIV_ITERS, 32: radix-2 divider iterations. Must equal the data width.
- DIV0_LO, 32'hFFFFFFFF: LO value written on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  EX holds a valid MDU op. Op and operands are held stable while stall_o=1.
- op_i  in  4  MDU opcode (package enum)
- opa_i  in  32  rs operand
- opb_i  in  32  rt operand
- hi_i  in  32  current HI, already forwarded by EX
- lo_i  in  32  current LO, already forwarded by EX
- annul_i  in  1  flush/exception: abort the current op
- stall_o  out  1  stall request to CTRL (combinational)
- busy_o  out  1  FSM not IDLE (registered)
- whilo_o  out  1  HI/LO write enable, 1-cycle pulse
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data

Behaviour:
- Reset: on rst=1 at a clock edge, state=IDLE; all regs cleared; stall_o=0, busy_o=0, whilo_o=0, hi_o=0, lo_o=0. Reset mid-operation discards the op.

FSM states: IDLE, MUL, DIV, DONE.

IDLE
- start_i=1 and annul_i=0: latch op and operands; stall_o=1 this cycle.
- Next state:
  - MULT/MULTU: DONE, with the 64-bit product registered.
  - MADD/MADDU/MSUB/MSUBU: MUL, with the product registered.
  - DIV/DIVU, opb!=0: DIV. Load divider with |opa|, |opb| (signed op) or raw operands (unsigned op).
  - DIV/DIVU, opb==0: DONE, with hi=opa, lo=DIV0_LO.
- Unrecognised op: no stall, stay IDLE.

MUL
- Register {hi_i,lo_i} + product (MADD*) or {hi_i,lo_i} - product (MSUB*), 64-bit modulo.
- Next state DONE; stall_o=1.

DIV
- One restoring-division iteration per cycle, DIV_ITERS cycles; stall_o=1.
- After the last iteration, next state DONE.
- Signed fix-up, registered on entry to DONE:
  - quotient negated if opa[31]^opb[31];
  - remainder takes the sign of opa.
- -2^31 / -1 yields lo=0x80000000, hi=0 (wraps, no trap).

DONE
- whilo_o=1, hi_o/lo_o=result, stall_o=0. Next state IDLE.
- EX advances on this edge and the next instruction is seen in IDLE.

Signed multiply
- Operands made absolute; product negated when the signs differ.
- Unsigned ops use raw operands.

Stall counts before the DONE cycle:
- MULT*: 1
- MADD*/MSUB*: 2
- DIV*: 1 + DIV_ITERS = 33
- div-by-zero: 1

annul_i
- Has priority over everything except rst.
- In any state: next state IDLE; whilo_o forced 0 and stall_o forced 0 in that cycle; divider state discarded.

Other timing rules
- busy_o is registered, high in MUL, DIV and DONE.
- hi_o/lo_o hold their last value outside DONE; only whilo_o qualifies them.
- The MADD accumulate uses hi_i/lo_i sampled in MUL. EX guarantees the forwarding is valid because the pipeline is stalled.

Decomposition:
- Shared package `mdu_pkg` holds:
  - `mdu_op_e` (4-bit): NOP, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU;
  - `mdu_state_e`;
  - constants DATA_W=32, DWORD_W=64.
- The ID-stage aluop to `mdu_op_e` mapping also lives in the package.
- One sub-module, `mdu_div_core`: unsigned restoring divider with load/step/done, a 6-bit iteration counter and 64-bit partial-remainder/quotient register.
- Sign handling and the FSM stay in `mdu_ctrl`.

Test Plan:
- MULT, opa=-3 (0xFFFFFFFD), opb=5 -> 1 stall cycle, then whilo_o=1 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MADDU, hi_i=0, lo_i=0xFFFFFFFF, opa=2, opb=3 -> 2 stall cycles, then hi=0x00000001, lo=0x00000005.
- MSUB, hi_i=0, lo_i=10, opa=-2, opb=4 -> hi=0, lo=18.
- DIVU 100/7 -> exactly 33 stall cycles, then lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 -> 1 stall cycle, then hi=5, lo=0xFFFFFFFF.
- DIV started, annul_i=1 on the 10th DIV cycle -> stall_o=0 and no whilo_o pulse that cycle; IDLE next cycle; a following MULT 2*2 completes with lo=4.
- rst=1 asserted mid-DIV -> all outputs 0 next cycle, busy_o=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Also holds the mapping from ID-stage aluop codes to MDU opcodes.
package mdu_pkg;

  localparam int DATA_W  = 32;
  localparam int DWORD_W = 64;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_MADD  = 4'd3,
    MDU_MADDU = 4'd4,
    MDU_MSUB  = 4'd5,
    MDU_MSUBU = 4'd6,
    MDU_DIV   = 4'd7,
    MDU_DIVU  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic mdu_op_valid(input mdu_op_e op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU,
                      MDU_MSUB, MDU_MSUBU, MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic mdu_op_signed(input mdu_op_e op);
    return op inside {MDU_MULT, MDU_MADD, MDU_MSUB, MDU_DIV};
  endfunction

  // ID-stage aluop encodings; anything else is not an MDU instruction.
  function automatic mdu_op_e aluop_to_mdu(input logic [7:0] aluop);
    case (aluop)
      8'h18:   return MDU_MULT;
      8'h19:   return MDU_MULTU;
      8'hA0:   return MDU_MADD;
      8'hA1:   return MDU_MADDU;
      8'hA4:   return MDU_MSUB;
      8'hA5:   return MDU_MSUBU;
      8'h1A:   return MDU_DIV;
      8'h1B:   return MDU_DIVU;
      default: return MDU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned radix-2 restoring divider, one iteration per step.
// done/quot/rem reflect the step taken this cycle, so the caller can register the final result on the same edge.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  logic [DWORD_W-1:0] rq_reg;
  logic [DWORD_W-1:0] rq_next;
  logic [DATA_W-1:0]  divisor_reg;
  logic [5:0]         cnt_reg;
  logic [DWORD_W:0]   shifted;
  logic [DATA_W:0]    trial;

  // The 33-bit trial keeps the carry out of the shifted remainder.
  always_comb begin
    shifted = {rq_reg, 1'b0};
    trial   = shifted[DWORD_W:DATA_W] - {1'b0, divisor_reg};
    if (trial[DATA_W])
      rq_next = shifted[DWORD_W-1:0];
    else
      rq_next = {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_reg      <= '0;
      divisor_reg <= '0;
      cnt_reg     <= '0;
    end else if (load) begin
      rq_reg      <= {{DATA_W{1'b0}}, dividend};
      divisor_reg <= divisor;
      cnt_reg     <= '0;
    end else if (step) begin
      rq_reg  <= rq_next;
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  assign done = step && (cnt_reg == 6'(DIV_ITERS - 1));
  assign quot = rq_next[DATA_W-1:0];
  assign rem  = rq_next[DWORD_W-1:DATA_W];

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer beside EX: stalls the pipe while
// working and emits a single-cycle HI/LO write when the op completes.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int                DIV_ITERS = 32,
  parameter logic [DATA_W-1:0] DIV0_LO   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  mdu_state_e         state_reg, state_next;
  mdu_op_e            op_reg;
  logic               opa_neg_reg, opb_neg_reg;
  logic [DWORD_W-1:0] prod_reg;
  logic [DWORD_W-1:0] result_reg;
  logic               busy_reg;

  mdu_op_e            op_in;
  logic               sgn_in, accept;
  logic [DATA_W-1:0]  abs_a, abs_b;
  logic [DWORD_W-1:0] prod_mag, prod_in, acc;
  logic               div_load, div_step, div_done;
  logic [DATA_W-1:0]  div_quot, div_rem, q_fix, r_fix;

  assign op_in  = mdu_op_e'(op_i);
  assign sgn_in = mdu_op_signed(op_in);
  assign accept = (state_reg == ST_IDLE) && start_i && !annul_i && mdu_op_valid(op_in);

  // Signed ops work on magnitudes; the sign is restored afterwards.
  always_comb begin
    abs_a    = (sgn_in && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    abs_b    = (sgn_in && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    prod_mag = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
    prod_in  = (sgn_in && (opa_i[DATA_W-1] ^ opb_i[DATA_W-1])) ? -prod_mag : prod_mag;
    acc      = (op_reg inside {MDU_MADD, MDU_MADDU}) ? {hi_i, lo_i} + prod_reg
                                                     : {hi_i, lo_i} - prod_reg;
    q_fix    = (op_reg == MDU_DIV && (opa_neg_reg ^ opb_neg_reg)) ? -div_quot : div_quot;
    r_fix    = (op_reg == MDU_DIV && opa_neg_reg) ? -div_rem : div_rem;
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    whilo_o    = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    if (annul_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            stall_o = 1'b1;
            if (op_in inside {MDU_MULT, MDU_MULTU})
              state_next = ST_DONE;
            else if (op_in inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU})
              state_next = ST_MUL;
            else if (opb_i == '0)
              state_next = ST_DONE;
            else begin
              div_load   = 1'b1;
              state_next = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          stall_o    = 1'b1;
          state_next = ST_DONE;
        end
        ST_DIV: begin
          stall_o  = 1'b1;
          div_step = 1'b1;
          if (div_done)
            state_next = ST_DONE;
        end
        ST_DONE: begin
          whilo_o    = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // result_reg only changes on the edge into DONE, so hi_o/lo_o hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= MDU_NOP;
      opa_neg_reg <= 1'b0;
      opb_neg_reg <= 1'b0;
      prod_reg    <= '0;
      result_reg  <= '0;
    end else begin
      if (accept) begin
        op_reg      <= op_in;
        opa_neg_reg <= opa_i[DATA_W-1];
        opb_neg_reg <= opb_i[DATA_W-1];
        prod_reg    <= prod_in;
        if (op_in inside {MDU_MULT, MDU_MULTU})
          result_reg <= prod_in;
        else if ((op_in inside {MDU_DIV, MDU_DIVU}) && opb_i == '0)
          result_reg <= {opa_i, DIV0_LO};
      end
      if (state_reg == ST_MUL && !annul_i)
        result_reg <= acc;
      if (state_reg == ST_DIV && !annul_i && div_done)
        result_reg <= {r_fix, q_fix};
    end
  end

  mdu_div_core #(
    .DIV_ITERS(DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst | annul_i),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  assign busy_o = busy_reg;
  assign hi_o   = result_reg[DWORD_W-1:DATA_W];
  assign lo_o   = result_reg[DATA_W-1:0];

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: each op is issued like EX would and the
// stall length and HI/LO write are compared to hand-computed values.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, annul_i;
  logic [3:0]  op_i;
  logic [31:0] opa_i, opb_i, hi_i, lo_i;
  logic        stall_o, busy_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .annul_i (annul_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .whilo_o (whilo_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  // Drive one op at a negedge and hold it until stall_o drops (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, h, l,
                       output int stalls);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l;
    stalls = 0;
    #1;
    while (stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    $display("op=%0d a=%h b=%h stalls=%0d whilo=%b hi=%h lo=%h", op, a, b, stalls, whilo_o, hi_o, lo_o);
  endtask

  task automatic end_op();
    @(negedge clk);
    start_i = 1'b0; op_i = MDU_NOP;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = MDU_NOP;
    opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall_o, busy_o, whilo_o, hi_o, lo_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b busy=%b whilo=%b hi=%h lo=%h, want all 0", stall_o, busy_o, whilo_o, hi_o, lo_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int s;
    do_op(MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL mult_stalls: got %0d want 1", s); end
    checks++; if (whilo_o !== 1'b1) begin errors++; $display("FAIL mult_whilo: got %b want 1", whilo_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mult_busy_done: got %b want 1", busy_o); end
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffff1", hi_o, lo_o); end
    end_op();
    checks++; if (whilo_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mult_after: got whilo=%b busy=%b want 0 0", whilo_o, busy_o); end
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_hold: got %h_%h want ffffffff_fffffff1", hi_o, lo_o); end
  endtask

  task automatic test_madd();
    int s;
    do_op(MDU_MADDU, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFF, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL maddu_stalls: got %0d want 2", s); end
    checks++; if (whilo_o !== 1'b1) begin errors++; $display("FAIL maddu_whilo: got %b want 1", whilo_o); end
    checks++; if ({hi_o, lo_o} !== 64'h00000001_00000005) begin errors++; $display("FAIL maddu_result: got %h_%h want 00000001_00000005", hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_msub();
    int s;
    do_op(MDU_MSUB, 32'hFFFFFFFE, 32'd4, 32'h0, 32'd10, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL msub_stalls: got %0d want 2", s); end
    checks++; if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'h0, 32'd18}) begin errors++; $display("FAIL msub_result: got whilo=%b %h_%h want 1 00000000_00000012", whilo_o, hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_divu();
    int s;
    do_op(MDU_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, s);
    checks++; if (s !== 33) begin errors++; $display("FAIL divu_stalls: got %0d want 33", s); end
    checks++; if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got whilo=%b %h_%h want 1 00000002_0000000e", whilo_o, hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_div_signed();
    int s;
    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, s);
    checks++; if (s !== 33) begin errors++; $display("FAIL div_neg_a_stalls: got %0d want 33", s); end
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg_a_result: got %h_%h want ffffffff_fffffffd", hi_o, lo_o); end
    end_op();
    do_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, s);
    checks++; if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd1, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_neg_b_result: got whilo=%b %h_%h want 1 00000001_fffffffd", whilo_o, hi_o, lo_o); end
    end_op();
    do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, s);
    checks++; if ({hi_o, lo_o} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow_result: got %h_%h want 00000000_80000000", hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_div_zero();
    int s;
    do_op(MDU_DIV, 32'd5, 32'd0, 32'h0, 32'h0, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL div0_stalls: got %0d want 1", s); end
    checks++; if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd5, 32'hFFFFFFFF}) begin errors++; $display("FAIL div0_result: got whilo=%b %h_%h want 1 00000005_ffffffff", whilo_o, hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_unknown_op();
    int s;
    do_op(4'hF, 32'd9, 32'd9, 32'h0, 32'h0, s);
    checks++; if (s !== 0 || whilo_o !== 1'b0) begin errors++; $display("FAIL unknown_op: got stalls=%0d whilo=%b want 0 0", s, whilo_o); end
    end_op();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL unknown_op_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_annul();
    int s;
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_DIV; opa_i = 32'd1000; opb_i = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    $display("annul on 10th DIV cycle: stall=%b whilo=%b busy=%b", stall_o, whilo_o, busy_o);
    checks++; if (stall_o !== 1'b0 || whilo_o !== 1'b0) begin errors++; $display("FAIL annul_cycle: got stall=%b whilo=%b want 0 0", stall_o, whilo_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL annul_busy_before: got %b want 1", busy_o); end
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0; op_i = MDU_NOP;
    #1;
    checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL annul_idle: got busy=%b stall=%b want 0 0", busy_o, stall_o); end
    do_op(MDU_MULT, 32'd2, 32'd2, 32'h0, 32'h0, s);
    checks++; if ({s, whilo_o, hi_o, lo_o} !== {32'd1, 1'b1, 32'd0, 32'd4}) begin errors++; $display("FAIL annul_then_mult: got stalls=%0d whilo=%b %h_%h want 1 1 00000000_00000004", s, whilo_o, hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_back_to_back();
    int s;
    do_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, s);
    checks++; if ({hi_o, lo_o} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL b2b_multu: got %h_%h want 00000001_fffffffe", hi_o, lo_o); end
    do_op(MDU_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0, s);
    checks++; if ({s, whilo_o, hi_o, lo_o} !== {32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin errors++; $display("FAIL b2b_msubu: got stalls=%0d whilo=%b %h_%h want 2 1 ffffffff_ffffffff", s, whilo_o, hi_o, lo_o); end
    end_op();
  endtask

  task automatic test_rst_mid_div();
    int s;
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_DIVU; opa_i = 32'd100; opb_i = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; start_i = 1'b0; op_i = MDU_NOP;
    @(negedge clk);
    #1;
    $display("rst mid-DIV: stall=%b busy=%b whilo=%b hi=%h lo=%h", stall_o, busy_o, whilo_o, hi_o, lo_o);
    checks++; if ({stall_o, busy_o, whilo_o, hi_o, lo_o} !== '0) begin errors++; $display("FAIL rst_mid_div: got stall=%b busy=%b whilo=%b hi=%h lo=%h want all 0", stall_o, busy_o, whilo_o, hi_o, lo_o); end
    rst = 1'b0;
    do_op(MDU_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, s);
    checks++; if ({s, hi_o, lo_o} !== {32'd33, 32'd2, 32'd14}) begin errors++; $display("FAIL rst_recover_divu: got stalls=%0d %h_%h want 33 00000002_0000000e", s, hi_o, lo_o); end
    end_op();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd();
    test_msub();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_unknown_op();
    test_back_to_back();
    test_annul();
    test_rst_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
